// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal shift register: hold / shift right / shift left / load,
// plus an auto-shift sequencer. Define UNIV_SR_ROTATE_EN to make every shift a rotate.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] data,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] amount,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             dir_q, dir_nx;
  logic [WIDTH-1:0] q_r, q_nx;
  logic             done_r, done_nx;

  logic             fill_r, fill_l;
  logic [WIDTH-1:0] shr, shl;

`ifdef UNIV_SR_ROTATE_EN
  assign fill_r = q_r[0];
  assign fill_l = q_r[WIDTH-1];
`else
  assign fill_r = sin_r;
  assign fill_l = sin_l;
`endif

  assign shr = {fill_r, q_r[WIDTH-1:1]};
  assign shl = {q_r[WIDTH-2:0], fill_l};

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    dir_nx   = dir_q;
    q_nx     = q_r;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          // Accepting edge: q is untouched and mode is ignored.
          if (amount != '0) begin
            state_nx = SHIFT;
            cnt_nx   = amount;
            dir_nx   = dir;
          end else begin
            done_nx  = 1'b1;
          end
        end else begin
          case (mode)
            MODE_HOLD:  q_nx = q_r;
            MODE_RIGHT: q_nx = shr;
            MODE_LEFT:  q_nx = shl;
            MODE_LOAD:  q_nx = data;
            default:    q_nx = q_r;
          endcase
        end
      end
      SHIFT: begin
        q_nx   = dir_q ? shl : shr;
        cnt_nx = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (clear) begin
      state  <= IDLE;
      cnt    <= '0;
      dir_q  <= 1'b0;
      q_r    <= '0;
      done_r <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      dir_q  <= dir_nx;
      q_r    <= q_nx;
      done_r <= done_nx;
    end
  end

  assign q      = q_r;
  assign qbar   = ~q_r;
  assign sout_r = q_r[0];
  assign sout_l = q_r[WIDTH-1];
  assign busy   = (state == SHIFT);
  assign done   = done_r;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg (WIDTH=8, CNT_W=4).
// Expectations follow UNIV_SR_ROTATE_EN when the bench is built with it defined.
module tb_univ_shift_reg;

  logic       clock = 1'b0;
  logic       clear;
  logic [1:0] mode;
  logic [7:0] data;
  logic       sin_r, sin_l, start, dir;
  logic [3:0] amount;
  logic [7:0] q, qbar;
  logic       sout_r, sout_l, busy, done;

  int checks = 0;
  int errors = 0;

  univ_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
    .clock(clock), .clear(clear), .mode(mode), .data(data),
    .sin_r(sin_r), .sin_l(sin_l), .start(start), .dir(dir), .amount(amount),
    .q(q), .qbar(qbar), .sout_r(sout_r), .sout_l(sout_l),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_q(input string name, input logic [7:0] exp);
    checks++;
    if (q !== exp || qbar !== ~exp) begin
      errors++;
      $display("FAIL %s: q=%h qbar=%h, expected q=%h qbar=%h", name, q, qbar, exp, ~exp);
    end
  endtask

  task automatic chk_bd(input string name, input logic exp_busy, input logic exp_done);
    checks++;
    if (busy !== exp_busy || done !== exp_done) begin
      errors++;
      $display("FAIL %s: busy=%b done=%b, expected busy=%b done=%b",
               name, busy, done, exp_busy, exp_done);
    end
  endtask

  task automatic load(input logic [7:0] v);
    mode = 2'b11; data = v; step(); mode = 2'b00;
  endtask

  task automatic test_reset();
    clear = 1'b1; mode = 2'b11; data = 8'hFF;
    step(); step();
    chk_q("reset_q", 8'h00);
    chk_bd("reset_flags", 1'b0, 1'b0);
    clear = 1'b0; mode = 2'b00;
  endtask

  task automatic test_manual();
    logic [7:0] e_left;
`ifdef UNIV_SR_ROTATE_EN
    e_left = 8'hA5;
`else
    e_left = 8'hA4;
`endif
    load(8'hA5);
    chk_q("manual_load", 8'hA5);
    mode = 2'b01; sin_r = 1'b1; step();
    chk_q("manual_right", 8'hD2);
    mode = 2'b10; sin_l = 1'b0; step();
    chk_q("manual_left", e_left);
    mode = 2'b00;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_q("manual_hold", e_left);
      checks++;
      if (sout_l !== e_left[7] || sout_r !== e_left[0]) begin
        errors++;
        $display("FAIL hold_sout: sout_l=%b sout_r=%b, expected %b %b",
                 sout_l, sout_r, e_left[7], e_left[0]);
      end
    end
  endtask

  task automatic test_auto_left();
    logic [7:0] exp [3];
`ifdef UNIV_SR_ROTATE_EN
    exp = '{8'h03, 8'h06, 8'h0C};
`else
    exp = '{8'h02, 8'h04, 8'h08};
`endif
    load(8'h81);
    start = 1'b1; dir = 1'b1; amount = 4'd3; sin_l = 1'b0; mode = 2'b01;
    step();
    start = 1'b0; mode = 2'b00;
    chk_q("auto_accept_q", 8'h81);
    chk_bd("auto_accept", 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_q("auto_left_q", exp[i]);
      chk_bd("auto_left_flags", (i < 2), (i == 2));
    end
    step();
    chk_bd("auto_left_after", 1'b0, 1'b0);
    chk_q("auto_left_hold", exp[2]);
  endtask

  task automatic test_zero_and_ignore();
    int busy_cycles;
    int done_cycles;
    load(8'h3C);
    start = 1'b1; amount = 4'd0; step();
    start = 1'b0;
    chk_q("zero_q", 8'h3C);
    chk_bd("zero_flags", 1'b0, 1'b1);
    step();
    chk_bd("zero_after", 1'b0, 1'b0);

    load(8'h80);
    start = 1'b1; dir = 1'b0; amount = 4'd5; sin_r = 1'b0; step();
    chk_bd("ign_accept", 1'b1, 1'b0);
    // Disturb every control input while the run is in progress.
    start = 1'b1; amount = 4'd1; dir = 1'b1; mode = 2'b11; data = 8'hFF;
    busy_cycles = 1; done_cycles = 0;
    for (int i = 0; i < 8 && done_cycles == 0; i++) begin
      step();
      if (i == 0) start = 1'b0;
      if (busy) busy_cycles++;
      if (done) done_cycles++;
    end
    mode = 2'b00;
    checks++;
    if (busy_cycles != 5 || done_cycles != 1) begin
      errors++;
      $display("FAIL ignore_count: busy_cycles=%0d done=%0d, expected 5 and 1",
               busy_cycles, done_cycles);
    end
    chk_q("ignore_q", 8'h04);
    step();
    chk_bd("ignore_after", 1'b0, 1'b0);
  endtask

  task automatic test_abort_and_back_to_back();
    logic [7:0] e_abort, e_fresh, e_b2b [2];
`ifdef UNIV_SR_ROTATE_EN
    e_abort = 8'h10; e_fresh = 8'h00; e_b2b = '{8'h00, 8'h00};
`else
    e_abort = 8'h1F; e_fresh = 8'h03; e_b2b = '{8'h81, 8'hC0};
`endif
    load(8'h01);
    start = 1'b1; dir = 1'b1; amount = 4'd10; sin_l = 1'b1; step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk_q("abort_4_shifts", e_abort);
    clear = 1'b1; step();
    clear = 1'b0;
    chk_q("abort_q", 8'h00);
    chk_bd("abort_flags", 1'b0, 1'b0);
    step();
    chk_bd("abort_no_done", 1'b0, 1'b0);

    start = 1'b1; dir = 1'b1; amount = 4'd2; sin_l = 1'b1; step();
    start = 1'b0;
    chk_bd("fresh_accept", 1'b1, 1'b0);
    step(); step();
    chk_q("fresh_q", e_fresh);
    chk_bd("fresh_done", 1'b0, 1'b1);

    // Start issued during the done cycle.
    start = 1'b1; dir = 1'b0; amount = 4'd2; sin_r = 1'b1; step();
    start = 1'b0;
    chk_bd("b2b_accept", 1'b1, 1'b0);
    chk_q("b2b_accept_q", e_fresh);
    for (int i = 0; i < 2; i++) begin
      step();
      chk_q("b2b_q", e_b2b[i]);
      chk_bd("b2b_flags", (i == 0), (i == 1));
    end
    step();
    chk_bd("b2b_after", 1'b0, 1'b0);
  endtask

  initial begin
    clear = 1'b0; mode = 2'b00; data = '0; sin_r = 1'b0; sin_l = 1'b0;
    start = 1'b0; dir = 1'b0; amount = '0;
    #1;
    test_reset();
    test_manual();
    test_auto_left();
    test_zero_and_ignore();
    test_abort_and_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
